apu_dispatcher: RTL and testbench

Core-side initiator of the APU offload interface served by the vector accelerator. It accepts decoded vector commands from the issue stage and drives apu_req/apu_operands/apu_op/apu_flags_o until granted. It tracks outstanding requests in order and buffers apu_rvalid results, because the accelerator cannot be stalled, then returns them to writeback with their destination tag.

---
 rtl/accelerator_pkg.sv | 25 ++
 rtl/apu_dispatcher_if.sv | 43 ++++
 rtl/apu_sync_fifo.sv | 54 +++++
 rtl/apu_dispatcher.sv | 129 ++++++++++++
 tb/tb_apu_dispatcher.sv | 268 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/accelerator_pkg.sv
// Shared types for the APU offload path: command and response records
// and the dispatcher state encoding.
package accelerator_pkg;

   localparam int APU_NUM_OPERANDS = 3;

   typedef struct packed {
      logic [APU_NUM_OPERANDS-1:0][31:0] operands;
      logic [5:0]                        op;
      logic [14:0]                       flags;
      logic [4:0]                        rd;
   } apu_cmd_t;

   typedef struct packed {
      logic [31:0] result;
      logic [4:0]  flags;
      logic [4:0]  rd;
   } apu_rsp_t;

   typedef enum logic [0:0] {
      IDLE = 1'b0,
      REQ  = 1'b1
   } apu_disp_state_t;

endpackage

// File: rtl/apu_dispatcher_if.sv
// Bundle of the issue-side command port, the writeback response port and
// the accelerator request/response port. The dispatcher is the master.
interface apu_dispatcher_if;
   logic             cmd_valid;
   logic             cmd_ready;
   logic [2:0][31:0] cmd_operands;
   logic [5:0]       cmd_op;
   logic [14:0]      cmd_flags;
   logic [4:0]       cmd_rd;

   logic             rsp_valid;
   logic             rsp_ready;
   logic [31:0]      rsp_result;
   logic [4:0]       rsp_flags;
   logic [4:0]       rsp_rd;

   logic             apu_req;
   logic             apu_gnt;
   logic [2:0][31:0] apu_operands;
   logic [5:0]       apu_op;
   logic [14:0]      apu_flags_o;
   logic             apu_rvalid;
   logic [31:0]      apu_result;
   logic [4:0]       apu_flags_i;

   modport master (
      input  cmd_valid, cmd_operands, cmd_op, cmd_flags, cmd_rd,
      output cmd_ready,
      output rsp_valid, rsp_result, rsp_flags, rsp_rd,
      input  rsp_ready,
      output apu_req, apu_operands, apu_op, apu_flags_o,
      input  apu_gnt, apu_rvalid, apu_result, apu_flags_i
   );

   modport slave (
      output cmd_valid, cmd_operands, cmd_op, cmd_flags, cmd_rd,
      input  cmd_ready,
      input  rsp_valid, rsp_result, rsp_flags, rsp_rd,
      output rsp_ready,
      input  apu_req, apu_operands, apu_op, apu_flags_o,
      output apu_gnt, apu_rvalid, apu_result, apu_flags_i
   );
endinterface

// File: rtl/apu_sync_fifo.sv
// Show-ahead synchronous FIFO, DEPTH 1..8. Push while full is accepted
// only when a pop happens in the same cycle; pop while empty is ignored.
module apu_sync_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 2
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             i_push,
   input  logic [WIDTH-1:0] i_data,
   input  logic             i_pop,
   output logic [WIDTH-1:0] o_data,
   output logic             o_full,
   output logic             o_empty,
   output logic [3:0]       o_count
);
   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [AW-1:0]    r_wptr;
   logic [AW-1:0]    r_rptr;
   logic [3:0]       r_count;
   logic             w_do_push;
   logic             w_do_pop;

   assign o_empty   = (r_count == 4'd0);
   assign o_full    = (r_count == 4'(DEPTH));
   assign o_count   = r_count;
   assign o_data    = r_mem[r_rptr];
   assign w_do_pop  = i_pop & ~o_empty;
   assign w_do_push = i_push & (~o_full | w_do_pop);

   // Storage array; contents need no reset because count gates visibility.
   always_ff @(posedge clk) begin
      if (w_do_push) r_mem[r_wptr] <= i_data;
   end

   // Pointer and occupancy bookkeeping.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_wptr  <= '0;
         r_rptr  <= '0;
         r_count <= 4'd0;
      end else begin
         if (w_do_push) r_wptr <= (r_wptr == AW'(DEPTH-1)) ? '0 : r_wptr + 1'b1;
         if (w_do_pop)  r_rptr <= (r_rptr == AW'(DEPTH-1)) ? '0 : r_rptr + 1'b1;
         case ({w_do_push, w_do_pop})
            2'b10:   r_count <= r_count + 4'd1;
            2'b01:   r_count <= r_count - 4'd1;
            default: r_count <= r_count;
         endcase
      end
   end
endmodule

// File: rtl/apu_dispatcher.sv
// APU offload initiator: registers one command at a time, holds it on the
// accelerator port until granted, tracks granted tags in order and buffers
// results (the accelerator cannot be stalled) for writeback.
// Optional watchdog: define APU_DISPATCH_TIMEOUT_EN.
//
// state | meaning
// IDLE  | no request on the bus; accept a command when a credit is free
// REQ   | apu_req asserted with stable payload, waiting for apu_gnt
module apu_dispatcher
   import accelerator_pkg::*;
#(
   parameter int MAX_OUTSTANDING = 2,
   parameter int TIMEOUT_CYCLES  = 255
) (
   input  logic               clk,
   input  logic               reset,
   apu_dispatcher_if.master   bus,
   output logic [3:0]         outstanding,
   output logic               protocol_error,
   output logic               timeout_error
);
   localparam logic [0:0] S_IDLE = 1'(IDLE);
   localparam logic [0:0] S_REQ  = 1'(REQ);

   logic [0:0] r_state;
   apu_cmd_t   r_cmd;
   logic       r_proto_err;

   logic       w_tag_full, w_tag_empty;
   logic [3:0] w_tag_count;
   logic [4:0] w_tag_head;
   logic       w_rsp_full, w_rsp_empty;
   logic [3:0] w_rsp_count;
   apu_rsp_t   w_rsp_in, w_rsp_head;
   logic [4:0] w_credits;
   logic       w_credit_ok;
   logic       w_accept;
   logic       w_gnt;
   logic       w_rv_ok;
   logic       w_rv_drop;

   // Outstanding is exactly the number of tags waiting for their result.
   assign outstanding   = w_tag_count;
   assign w_credits     = {1'b0, w_tag_count} + {1'b0, w_rsp_count};
   assign w_credit_ok   = (w_credits < 5'(MAX_OUTSTANDING)) & ~w_tag_full & ~w_rsp_full;
   assign bus.cmd_ready = (r_state == S_IDLE) & w_credit_ok;
   assign w_accept      = bus.cmd_valid & bus.cmd_ready;
   assign w_gnt         = (r_state == S_REQ) & bus.apu_gnt;
   assign w_rv_ok       = bus.apu_rvalid & ~w_tag_empty;
   assign w_rv_drop     = bus.apu_rvalid & w_tag_empty;

   assign bus.apu_req      = (r_state == S_REQ);
   assign bus.apu_operands = r_cmd.operands;
   assign bus.apu_op       = r_cmd.op;
   assign bus.apu_flags_o  = r_cmd.flags;

   assign w_rsp_in       = '{result: bus.apu_result, flags: bus.apu_flags_i, rd: w_tag_head};
   assign bus.rsp_valid  = ~w_rsp_empty;
   assign bus.rsp_result = w_rsp_head.result;
   assign bus.rsp_flags  = w_rsp_head.flags;
   assign bus.rsp_rd     = w_rsp_head.rd;
   assign protocol_error = r_proto_err;

   // Request FSM and command payload capture.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state <= S_IDLE;
         r_cmd   <= '0;
      end else begin
         case (r_state)
            S_IDLE: if (w_accept) begin
               r_state <= S_REQ;
               r_cmd   <= '{operands: bus.cmd_operands, op: bus.cmd_op,
                            flags: bus.cmd_flags, rd: bus.cmd_rd};
            end
            default: if (w_gnt) r_state <= S_IDLE;
         endcase
      end
   end

   // Sticky flag for a result beat with no granted request to match it.
   always_ff @(posedge clk or posedge reset) begin
      if (reset)          r_proto_err <= 1'b0;
      else if (w_rv_drop) r_proto_err <= 1'b1;
   end

   apu_sync_fifo #(.WIDTH(5), .DEPTH(MAX_OUTSTANDING)) u_tag_fifo (
      .clk(clk), .rst(reset),
      .i_push(w_gnt), .i_data(r_cmd.rd), .i_pop(w_rv_ok),
      .o_data(w_tag_head), .o_full(w_tag_full), .o_empty(w_tag_empty),
      .o_count(w_tag_count)
   );

   apu_sync_fifo #(.WIDTH($bits(apu_rsp_t)), .DEPTH(MAX_OUTSTANDING)) u_rsp_fifo (
      .clk(clk), .rst(reset),
      .i_push(w_rv_ok), .i_data(w_rsp_in), .i_pop(bus.rsp_valid & bus.rsp_ready),
      .o_data(w_rsp_head), .o_full(w_rsp_full), .o_empty(w_rsp_empty),
      .o_count(w_rsp_count)
   );

`ifdef APU_DISPATCH_TIMEOUT_EN
   localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

   logic [TW-1:0] r_wd_cnt;
   logic [TW-1:0] w_wd_next;
   logic          r_timeout;
   logic          w_wd_busy;

   assign w_wd_busy = ((r_state == S_REQ) & ~bus.apu_gnt) |
                      ((w_tag_count != 4'd0) & ~bus.apu_rvalid);
   assign w_wd_next = (bus.apu_gnt | bus.apu_rvalid)           ? '0 :
                      (w_wd_busy & (r_wd_cnt != TW'(TIMEOUT_CYCLES))) ? r_wd_cnt + 1'b1 :
                      r_wd_cnt;
   assign timeout_error = r_timeout;

   // Watchdog: count stalled cycles, latch the flag at the limit.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_wd_cnt  <= '0;
         r_timeout <= 1'b0;
      end else begin
         r_wd_cnt <= w_wd_next;
         if (w_wd_next == TW'(TIMEOUT_CYCLES)) r_timeout <= 1'b1;
      end
   end
`else
   assign timeout_error = 1'b0;
`endif
endmodule

// File: tb/tb_apu_dispatcher.sv
// Directed bench for apu_dispatcher: table of single transactions plus
// hand-written sequences for credit gating, overlap, errors and reset.
module tb_apu_dispatcher;
   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic [3:0] outstanding;
   logic       protocol_error;
   logic       timeout_error;
   int         n_tests = 0;
   int         n_fail  = 0;

   apu_dispatcher_if bus_if ();

   apu_dispatcher #(.MAX_OUTSTANDING(2), .TIMEOUT_CYCLES(8)) dut (
      .clk(clk), .reset(reset), .bus(bus_if),
      .outstanding(outstanding), .protocol_error(protocol_error),
      .timeout_error(timeout_error)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [5:0]       op;
      logic [4:0]       rd;
      logic [2:0][31:0] ops;
      logic [14:0]      flags;
      int               gnt_delay;
      int               rv_delay;
      logic [31:0]      result;
      logic [4:0]       rflags;
      int               exp_req;
      logic [31:0]      exp_res;
      logic [4:0]       exp_rflags;
      logic [4:0]       exp_rd;
   } vec_t;

   vec_t vecs [3];

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string name, input logic [95:0] act, input logic [95:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic do_reset();
      reset = 1'b1;
      tick();
      tick();
      reset = 1'b0;
      tick();
   endtask

   task automatic drive_cmd(input logic [4:0] rd);
      bus_if.cmd_rd       = rd;
      bus_if.cmd_op       = {1'b1, rd};
      bus_if.cmd_flags    = {10'h0, rd};
      bus_if.cmd_operands = {32'(rd) + 32'd2, 32'(rd) + 32'd1, 32'(rd)};
      bus_if.cmd_valid    = 1'b1;
   endtask

   // Present a command, wait for acceptance, then grant it immediately.
   task automatic issue_grant(input logic [4:0] rd);
      int n = 0;
      drive_cmd(rd);
      while (!bus_if.cmd_ready && n < 20) begin tick(); n++; end
      if (n >= 20) check("issue_cmd_ready", 96'(bus_if.cmd_ready), 96'd1);
      tick();
      bus_if.cmd_valid = 1'b0;
      bus_if.apu_gnt   = 1'b1;
      tick();
      bus_if.apu_gnt   = 1'b0;
   endtask

   task automatic rvalid_beat(input logic [31:0] res, input logic [4:0] fl);
      bus_if.apu_rvalid  = 1'b1;
      bus_if.apu_result  = res;
      bus_if.apu_flags_i = fl;
      tick();
      bus_if.apu_rvalid  = 1'b0;
   endtask

   task automatic pop_check(input string name, input logic [4:0] rd, input logic [31:0] res);
      check({name, "_valid"}, 96'(bus_if.rsp_valid), 96'd1);
      check({name, "_rd"}, 96'(bus_if.rsp_rd), 96'(rd));
      check({name, "_result"}, 96'(bus_if.rsp_result), 96'(res));
      bus_if.rsp_ready = 1'b1;
      tick();
      bus_if.rsp_ready = 1'b0;
   endtask

   initial begin
      vec_t v;
      int   req_cnt;
      bit   stable_bad;

      vecs[0] = '{op: 6'h05, rd: 5'd3, ops: {32'd3, 32'd2, 32'd1}, flags: 15'h0001,
                  gnt_delay: 2, rv_delay: 4, result: 32'hDEADBEEF, rflags: 5'h1A,
                  exp_req: 3, exp_res: 32'hDEADBEEF, exp_rflags: 5'h1A, exp_rd: 5'd3};
      vecs[1] = '{op: 6'h3F, rd: 5'd31, ops: {32'hA5A5A5A5, 32'h0, 32'hFFFFFFFF},
                  flags: 15'h7FFF, gnt_delay: 0, rv_delay: 1, result: 32'h0,
                  rflags: 5'h1F, exp_req: 1, exp_res: 32'h0, exp_rflags: 5'h1F, exp_rd: 5'd31};
      vecs[2] = '{op: 6'h00, rd: 5'd0, ops: {32'h0BAD0000, 32'h12, 32'h80000000},
                  flags: 15'h2AAA, gnt_delay: 5, rv_delay: 2, result: 32'h12345678,
                  rflags: 5'h00, exp_req: 6, exp_res: 32'h12345678, exp_rflags: 5'h00, exp_rd: 5'd0};

      bus_if.cmd_valid = 1'b0; bus_if.cmd_operands = '0; bus_if.cmd_op = '0;
      bus_if.cmd_flags = '0;   bus_if.cmd_rd = '0;       bus_if.rsp_ready = 1'b0;
      bus_if.apu_gnt = 1'b0;   bus_if.apu_rvalid = 1'b0; bus_if.apu_result = '0;
      bus_if.apu_flags_i = '0;

      // Reset state
      tick();
      check("rst_apu_req", 96'(bus_if.apu_req), 96'd0);
      check("rst_apu_op", 96'(bus_if.apu_op), 96'd0);
      check("rst_apu_operands", 96'(bus_if.apu_operands), 96'd0);
      reset = 1'b0;
      tick();
      check("rst_cmd_ready", 96'(bus_if.cmd_ready), 96'd1);
      check("rst_rsp_valid", 96'(bus_if.rsp_valid), 96'd0);
      check("rst_outstanding", 96'(outstanding), 96'd0);
      check("rst_errors", 96'({protocol_error, timeout_error}), 96'd0);

      // Table of single transactions
      for (int i = 0; i < 3; i++) begin
         v = vecs[i];
         bus_if.cmd_op = v.op; bus_if.cmd_rd = v.rd; bus_if.cmd_operands = v.ops;
         bus_if.cmd_flags = v.flags; bus_if.cmd_valid = 1'b1;
         check($sformatf("v%0d_cmd_ready", i), 96'(bus_if.cmd_ready), 96'd1);
         tick();
         bus_if.cmd_valid = 1'b0;
         req_cnt = 0;
         stable_bad = 1'b0;
         for (int c = 0; c < 50 && bus_if.apu_req; c++) begin
            req_cnt++;
            if (bus_if.apu_operands !== v.ops || bus_if.apu_op !== v.op ||
                bus_if.apu_flags_o !== v.flags) stable_bad = 1'b1;
            bus_if.apu_gnt = (req_cnt == v.gnt_delay + 1);
            tick();
         end
         bus_if.apu_gnt = 1'b0;
         check($sformatf("v%0d_req_cycles", i), 96'(req_cnt), 96'(v.exp_req));
         check($sformatf("v%0d_payload_stable", i), 96'(stable_bad), 96'd0);
         check($sformatf("v%0d_outstanding1", i), 96'(outstanding), 96'd1);
         repeat (v.rv_delay - 1) tick();
         rvalid_beat(v.result, v.rflags);
         check($sformatf("v%0d_outstanding0", i), 96'(outstanding), 96'd0);
         check($sformatf("v%0d_rsp_flags", i), 96'(bus_if.rsp_flags), 96'(v.exp_rflags));
         pop_check($sformatf("v%0d_rsp", i), v.exp_rd, v.exp_res);
         check($sformatf("v%0d_rsp_empty", i), 96'(bus_if.rsp_valid), 96'd0);
      end

      // Credit gating with MAX_OUTSTANDING=2 and writeback stalled
      issue_grant(5'd1);
      issue_grant(5'd2);
      check("full_outstanding", 96'(outstanding), 96'd2);
      drive_cmd(5'd3);
      check("full_ready_a", 96'(bus_if.cmd_ready), 96'd0);
      rvalid_beat(32'h111, 5'd1);
      rvalid_beat(32'h222, 5'd2);
      tick();
      check("full_ready_b", 96'(bus_if.cmd_ready), 96'd0);
      check("full_rsp_stable_rd", 96'(bus_if.rsp_rd), 96'd1);
      bus_if.rsp_ready = 1'b1;
      check("full_ready_at_pop", 96'(bus_if.cmd_ready), 96'd0);
      tick();
      bus_if.rsp_ready = 1'b0;
      check("full_ready_after_pop", 96'(bus_if.cmd_ready), 96'd1);
      tick();
      bus_if.cmd_valid = 1'b0;
      check("full_req3", 96'(bus_if.apu_req), 96'd1);
      bus_if.apu_gnt = 1'b1; tick(); bus_if.apu_gnt = 1'b0;
      rvalid_beat(32'h333, 5'd3);
      pop_check("order2", 5'd2, 32'h222);
      pop_check("order3", 5'd3, 32'h333);
      check("order_outstanding", 96'(outstanding), 96'd0);

      // Grant of B in the same cycle as rvalid of A
      issue_grant(5'd7);
      drive_cmd(5'd9);
      tick();
      bus_if.cmd_valid  = 1'b0;
      bus_if.apu_gnt    = 1'b1;
      rvalid_beat(32'hCAFE, 5'h3);
      bus_if.apu_gnt    = 1'b0;
      check("ovl_outstanding", 96'(outstanding), 96'd1);
      check("ovl_rsp_flags", 96'(bus_if.rsp_flags), 96'h3);
      rvalid_beat(32'hBEEF, 5'h4);
      pop_check("ovl_a", 5'd7, 32'hCAFE);
      pop_check("ovl_b", 5'd9, 32'hBEEF);

      // Rvalid with nothing outstanding
      do_reset();
      rvalid_beat(32'h55, 5'h1);
      check("perr_flag", 96'(protocol_error), 96'd1);
      check("perr_rsp_valid", 96'(bus_if.rsp_valid), 96'd0);
      check("perr_outstanding", 96'(outstanding), 96'd0);
      tick();
      check("perr_sticky", 96'(protocol_error), 96'd1);

      // Rvalid in the same cycle as the first grant
      do_reset();
      check("perr_cleared", 96'(protocol_error), 96'd0);
      drive_cmd(5'd12);
      tick();
      bus_if.cmd_valid = 1'b0;
      bus_if.apu_gnt   = 1'b1;
      rvalid_beat(32'h77, 5'h0);
      bus_if.apu_gnt   = 1'b0;
      check("gnt_rv_perr", 96'(protocol_error), 96'd1);
      check("gnt_rv_outstanding", 96'(outstanding), 96'd1);
      check("gnt_rv_rsp_valid", 96'(bus_if.rsp_valid), 96'd0);

      // Reset while in REQ with one outstanding
      do_reset();
      issue_grant(5'd4);
      drive_cmd(5'd5);
      tick();
      bus_if.cmd_valid = 1'b0;
      check("rreq_req", 96'(bus_if.apu_req), 96'd1);
      check("rreq_out1", 96'(outstanding), 96'd1);
      #2 reset = 1'b1;
      #1;
      check("rreq_req_dropped", 96'(bus_if.apu_req), 96'd0);
      check("rreq_out0", 96'(outstanding), 96'd0);
      check("rreq_rsp_valid", 96'(bus_if.rsp_valid), 96'd0);
      tick();
      reset = 1'b0;
      tick();
      rvalid_beat(32'h99, 5'h2);
      check("rreq_late_perr", 96'(protocol_error), 96'd1);
      check("rreq_late_rsp", 96'(bus_if.rsp_valid), 96'd0);

      // Watchdog with grant withheld
      do_reset();
      drive_cmd(5'd6);
      tick();
      bus_if.cmd_valid = 1'b0;
`ifdef APU_DISPATCH_TIMEOUT_EN
      repeat (7) tick();
      check("wd_before_limit", 96'(timeout_error), 96'd0);
      tick();
      check("wd_at_limit", 96'(timeout_error), 96'd1);
`else
      repeat (20) tick();
      check("wd_tied_off", 96'(timeout_error), 96'd0);
`endif
      check("wd_still_req", 96'(bus_if.apu_req), 96'd1);
      bus_if.apu_gnt = 1'b1; tick(); bus_if.apu_gnt = 1'b0;
      check("wd_gnt_outstanding", 96'(outstanding), 96'd1);
      rvalid_beat(32'hABCD, 5'h5);
      pop_check("wd_rsp", 5'd6, 32'hABCD);
`ifdef APU_DISPATCH_TIMEOUT_EN
      check("wd_sticky", 96'(timeout_error), 96'd1);
`else
      check("wd_still_zero", 96'(timeout_error), 96'd0);
`endif

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
